// File: rtl/quick_uart_pkg.sv
// quick_uart_pkg
// Shared types and helpers for the quick_uart receive path.
//   entry_t      : one buffered receive entry {dropped flag, data byte}
//   ptr_width()  : pointer width for a power-of-two FIFO depth (min 1 bit)
package quick_uart_pkg;

    localparam int ENTRY_DATA_BITS = 8;

    typedef struct packed {
        logic                       dropped;
        logic [ENTRY_DATA_BITS-1:0] data;
    } entry_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/quick_uart_fifo_ram.sv
// quick_uart_fifo_ram
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. No reset; contents are don't-care until written.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module quick_uart_fifo_ram
    import quick_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [ptr_width(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic [ptr_width(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]            rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/quick_uart_rx_fifo.sv
// quick_uart_rx_fifo
// Elastic buffer behind quick_uart_rx. Stores {dropped, data} per byte,
// presents entries in order over valid/ready, keeps a saturating count of
// entries that arrived flagged as dropped, and a sticky overflow flag.
//   clk_i, rst_i          : clock, async active-high reset
//   flush_i               : sync flush of FIFO, drop counter and overflow
//   valid_i/ready_o       : upstream handshake, data_i + data_dropped_i
//   valid_o/ready_i       : downstream handshake, data_o + dropped_o
//   count_o               : occupancy
//   drop_count_o          : saturating count of flagged pushes
//   overflow_o            : sticky, valid_i seen while not ready
module quick_uart_rx_fifo
    import quick_uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_BITS  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_BITS-1:0]       data_i,
    input  logic                       data_dropped_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_BITS-1:0]       data_o,
    output logic                       dropped_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_BITS-1:0]        drop_count_o,
    output logic                       overflow_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       FULL    = CW'(DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic                ovf_q, ovf_d;

    logic                push, pop;
    logic [DATA_BITS:0]  rd_entry;

    // ready_o deliberately ignores ready_i: no pop-to-push bypass when full.
    assign ready_o = (count_q < FULL) && !flush_i;
    assign valid_o = (count_q != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (flush_i) begin
            // A same-cycle pop still handshakes downstream but is discarded here.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && data_dropped_i && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
            end
            if (valid_i && !ready_o) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    quick_uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS + 1)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({data_dropped_i, data_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign data_o       = rd_entry[DATA_BITS-1:0];
    assign dropped_o    = rd_entry[DATA_BITS];
    assign count_o      = count_q;
    assign drop_count_o = drop_cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_quick_uart_rx_fifo.sv
module tb_quick_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_i = 8'h00;
    logic       data_dropped_i = 1'b0;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       dropped_o;
    logic [4:0] count_o;
    logic [7:0] drop_count_o;
    logic       overflow_o;

    quick_uart_rx_fifo dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .data_dropped_i (data_dropped_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .dropped_o      (dropped_o),
        .count_o        (count_o),
        .drop_count_o   (drop_count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of expected entries plus plain counters.
    logic [8:0] exp_q[$];
    int         m_count = 0;
    int         m_drop  = 0;
    bit         m_ovf   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update at the clock edge, from the spec's rules.
    bit m_rdy, m_psh, m_pop;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
        end else begin
            m_rdy = (m_count < DEPTH) && !flush_i;
            m_psh = valid_i && m_rdy;
            m_pop = (m_count != 0) && ready_i;
            if (flush_i) begin
                exp_q.delete();
                m_count = 0;
                m_drop  = 0;
                m_ovf   = 1'b0;
            end else begin
                if (valid_i && !m_rdy) m_ovf = 1'b1;
                if (m_psh) begin
                    exp_q.push_back({data_dropped_i, data_i});
                    if (data_dropped_i && m_drop < 255) m_drop++;
                end
                m_count = m_count + int'(m_psh) - int'(m_pop);
            end
        end
    end

    // Monitor: status compare every cycle, pop-and-compare on each handshake.
    logic [8:0] head;
    always @(negedge clk) begin
        if (!rst) begin
            chk("count_o",      int'(count_o),      m_count);
            chk("valid_o",      int'(valid_o),      int'(m_count != 0));
            chk("ready_o",      int'(ready_o),      int'((m_count < DEPTH) && !flush_i));
            chk("drop_count_o", int'(drop_count_o), m_drop);
            chk("overflow_o",   int'(overflow_o),   int'(m_ovf));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("pop_on_empty_model", 1, 0);
                end else begin
                    head = exp_q.pop_front();
                    chk("data_o",    int'(data_o),    int'(head[7:0]));
                    chk("dropped_o", int'(dropped_o), int'(head[8]));
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit dr, input bit r, input bit f);
        valid_i        = v;
        data_i         = d;
        data_dropped_i = dr;
        ready_i        = r;
        flush_i        = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 8'h00, 0, 0, 0);                       // reset state checked by monitor

        // Single byte, then pop.
        cyc(1, 8'hA5, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // Fill to 16, hold valid while full (overflow), drain in order.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++)  cyc(1, 8'hEE, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // Refill, overflow, then flush (with a same-cycle pop).
        for (int i = 0; i < 18; i++) cyc(1, 8'(8'h40 + i), i[0], 0, 0);
        cyc(1, 8'h77, 1, 1, 1);
        cyc(0, 8'h00, 0, 0, 0);

        // 300 flagged pushes with continuous popping: drop counter saturates.
        for (int i = 0; i < 300; i++) cyc(1, 8'($urandom), 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // Occupancy held at 1 with push+pop every cycle.
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'h11, 0, 0, 0);
        for (int i = 0; i < 50; i++) cyc(1, 8'($urandom), 1'($urandom), 1, 0);
        cyc(0, 8'h00, 0, 1, 0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 149) == 0);
        end
        cyc(0, 8'h00, 0, 0, 1);

        // Async reset mid-stream with 5 entries held.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 1, 0, 0);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_count_o",      int'(count_o),      0);
        chk("rst_valid_o",      int'(valid_o),      0);
        chk("rst_ready_o",      int'(ready_o),      1);
        chk("rst_drop_count_o", int'(drop_count_o), 0);
        chk("rst_overflow_o",   int'(overflow_o),   0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 8'h3C, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0);

        chk("model_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
